// File: rtl/shared_gf4_inv_outmul_dom.sv
`default_nettype none
// ============================================================================
// Module   : shared_gf4_inv_outmul_dom
// Brief    : Masked GF(2^4) inverter back half: share-wise GF(2^2) inverse of
//            Delta, then two DOM-indep multipliers against delayed X and Y.
// Revision : 1.0 - initial release
// ============================================================================
module shared_gf4_inv_outmul_dom #(
    parameter int SHARES    = 2,
    parameter int PIPELINED = 1
) (
    input  logic                            ClkxCI,
    input  logic                            RstxRI,
    input  logic                            ValidxSI,
    input  logic [2*SHARES-1:0]             _XxDI,
    input  logic [2*SHARES-1:0]             _YxDI,
    input  logic [2*SHARES-1:0]             _DeltaxDI,
    input  logic [2*SHARES*(SHARES-1)-1:0]  _ZxDI,
    output logic [4*SHARES-1:0]             _QxDO,
    output logic                            ValidxSO
);

    localparam int ZHALF  = SHARES * (SHARES - 1);
    localparam int NTERMS = SHARES * SHARES;

    generate
        if (PIPELINED != 1) begin : g_bad_pipelined
            $error("shared_gf4_inv_outmul_dom: only PIPELINED = 1 is supported");
        end
    endgenerate

    // GF(2^2) product in the normal basis {W^2, W}: bit1 = W^2, bit0 = W.
    function automatic logic [1:0] gf2Mul(input logic [1:0] a, input logic [1:0] b);
        logic e;
        e = (a[1] ^ a[0]) & (b[1] ^ b[0]);
        return {(a[1] & b[1]) ^ e, (a[0] & b[0]) ^ e};
    endfunction

    logic [2*SHARES-1:0]  XdlyxDP;
    logic [2*SHARES-1:0]  YdlyxDP;
    logic                 VdlyxSP;
    logic [2*SHARES-1:0]  DeltaInvxD;
    logic [2*NTERMS-1:0]  FFhixDN;
    logic [2*NTERMS-1:0]  FFloxDN;
    logic [2*NTERMS-1:0]  FFhixDP;
    logic [2*NTERMS-1:0]  FFloxDP;
    logic [2*SHARES-1:0]  QhixD;
    logic [2*SHARES-1:0]  QloxD;

    // Inversion equals squaring, which is a plain bit swap per share.
    generate
        for (genvar j = 0; j < SHARES; j++) begin : g_inv
            assign DeltaInvxD[2*j +: 2] = {_DeltaxDI[2*j], _DeltaxDI[2*j+1]};
        end
    endgenerate

    generate
        for (genvar i = 0; i < SHARES; i++) begin : g_row
            for (genvar j = 0; j < SHARES; j++) begin : g_col
                localparam int T = i * SHARES + j;
                if (i == j) begin : g_dom
                    assign FFhixDN[2*T +: 2] = gf2Mul(XdlyxDP[2*i +: 2], DeltaInvxD[2*j +: 2]);
                    assign FFloxDN[2*T +: 2] = gf2Mul(YdlyxDP[2*i +: 2], DeltaInvxD[2*j +: 2]);
                end else begin : g_cross
                    // Term (i,j) and its transpose share one Z pair so it cancels on recombination.
                    localparam int P = (j > i) ? (i + j * (j - 1) / 2) : (j + i * (i - 1) / 2);
                    assign FFhixDN[2*T +: 2] = gf2Mul(XdlyxDP[2*i +: 2], DeltaInvxD[2*j +: 2])
                                               ^ _ZxDI[2*P +: 2];
                    assign FFloxDN[2*T +: 2] = gf2Mul(YdlyxDP[2*i +: 2], DeltaInvxD[2*j +: 2])
                                               ^ _ZxDI[ZHALF + 2*P +: 2];
                end
            end
        end
    endgenerate

    always_ff @(posedge ClkxCI or posedge RstxRI) begin
        if (RstxRI) begin
            XdlyxDP  <= '0;
            YdlyxDP  <= '0;
            VdlyxSP  <= 1'b0;
            FFhixDP  <= '0;
            FFloxDP  <= '0;
            ValidxSO <= 1'b0;
        end else begin
            XdlyxDP  <= _XxDI;
            YdlyxDP  <= _YxDI;
            VdlyxSP  <= ValidxSI;
            FFhixDP  <= FFhixDN;
            FFloxDP  <= FFloxDN;
            ValidxSO <= VdlyxSP;
        end
    end

    // Share compression happens only after the term registers.
    always_comb begin
        QhixD = '0;
        QloxD = '0;
        for (int i = 0; i < SHARES; i++) begin
            for (int j = 0; j < SHARES; j++) begin
                QhixD[2*i +: 2] = QhixD[2*i +: 2] ^ FFhixDP[2*(i*SHARES+j) +: 2];
                QloxD[2*i +: 2] = QloxD[2*i +: 2] ^ FFloxDP[2*(i*SHARES+j) +: 2];
            end
        end
    end

    generate
        for (genvar i = 0; i < SHARES; i++) begin : g_out
            assign _QxDO[4*i +: 4] = {QhixD[2*i +: 2], QloxD[2*i +: 2]};
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_shared_gf4_inv_outmul_dom.sv
`default_nettype none
// ============================================================================
// Module   : tb_shared_gf4_inv_outmul_dom
// Brief    : Directed bench with a log/antilog GF(4) reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shared_gf4_inv_outmul_dom;

    localparam int S  = 2;
    localparam int ZW = 2 * S * (S - 1);
    localparam int NE = 512;

    logic           ClkxCI = 1'b0;
    logic           RstxRI = 1'b1;
    logic           ValidxSI = 1'b0;
    logic [2*S-1:0] XxD = '0;
    logic [2*S-1:0] YxD = '0;
    logic [2*S-1:0] DeltaxD = '0;
    logic [ZW-1:0]  ZxD = '0;
    logic [4*S-1:0] QxD;
    logic           ValidxSO;

    int nVec = 0;
    int nErr = 0;
    int cyc  = 0;

    bit         eDef[NE];
    bit         eFull[NE];
    bit         eV[NE];
    logic [3:0] eQ[NE];
    bit         eLitDef[NE];
    logic [3:0] eLitQ[NE];

    logic [2*S-1:0] pendDelta = '0;
    logic [ZW-1:0]  pendZ = '0;

    shared_gf4_inv_outmul_dom #(.SHARES(S), .PIPELINED(1)) dut (
        .ClkxCI    (ClkxCI),
        .RstxRI    (RstxRI),
        .ValidxSI  (ValidxSI),
        ._XxDI     (XxD),
        ._YxDI     (YxD),
        ._DeltaxDI (DeltaxD),
        ._ZxDI     (ZxD),
        ._QxDO     (QxD),
        .ValidxSO  (ValidxSO)
    );

    always #5 ClkxCI = ~ClkxCI;
    always @(posedge ClkxCI) cyc <= cyc + 1;

    // GF(4) via discrete logs: 2'b11 = 1, 2'b01 = W, 2'b10 = W^2, W^3 = 1.
    function automatic int gLog(input logic [1:0] a);
        case (a)
            2'b01:   return 1;
            2'b10:   return 2;
            default: return 0;
        endcase
    endfunction

    function automatic logic [1:0] gExp(input int e);
        case (e % 3)
            1:       return 2'b01;
            2:       return 2'b10;
            default: return 2'b11;
        endcase
    endfunction

    function automatic logic [1:0] mMul(input logic [1:0] a, input logic [1:0] b);
        if (a == 2'b00 || b == 2'b00) return 2'b00;
        return gExp(gLog(a) + gLog(b));
    endfunction

    function automatic logic [1:0] mInv(input logic [1:0] a);
        if (a == 2'b00) return 2'b00;
        return gExp(3 - gLog(a));
    endfunction

    function automatic logic [3:0] recomb(input logic [4*S-1:0] q);
        logic [3:0] r;
        r = '0;
        for (int i = 0; i < S; i++) r = r ^ q[4*i +: 4];
        return r;
    endfunction

    always @(negedge ClkxCI) begin
        if (cyc < NE && eDef[cyc]) begin
            nVec++;
            if (ValidxSO !== eV[cyc]) begin
                nErr++;
                $display("FAIL valid cyc=%0d got=%b exp=%b", cyc, ValidxSO, eV[cyc]);
            end
            nVec++;
            if (recomb(QxD) !== eQ[cyc]) begin
                nErr++;
                $display("FAIL recombined_q cyc=%0d got=%b exp=%b", cyc, recomb(QxD), eQ[cyc]);
            end
            if (eFull[cyc]) begin
                nVec++;
                if (QxD !== '0) begin
                    nErr++;
                    $display("FAIL raw_q_zero cyc=%0d got=%h exp=0", cyc, QxD);
                end
            end
            if (eLitDef[cyc]) begin
                nVec++;
                if (recomb(QxD) !== eLitQ[cyc]) begin
                    nErr++;
                    $display("FAIL literal_q cyc=%0d got=%b exp=%b", cyc, recomb(QxD), eLitQ[cyc]);
                end
            end
        end
    end

    // Drives one operand's X/Y/valid plus the previous operand's Delta/Z; returns one cycle later.
    task automatic send(input bit v, input logic [1:0] x, input logic [1:0] y, input logic [1:0] d,
                        input logic [1:0] xm, input logic [1:0] ym, input logic [1:0] dm,
                        input logic [ZW-1:0] z, input bit lit, input logic [3:0] litQ);
        logic [3:0] m;
        XxD       = {xm, x ^ xm};
        YxD       = {ym, y ^ ym};
        ValidxSI  = v;
        DeltaxD   = pendDelta;
        ZxD       = pendZ;
        pendDelta = {dm, d ^ dm};
        pendZ     = z;
        m = {mMul(x, mInv(d)), mMul(y, mInv(d))};
        eDef[cyc+2]    = 1'b1;
        eFull[cyc+2]   = 1'b0;
        eV[cyc+2]      = v;
        eQ[cyc+2]      = m;
        eLitDef[cyc+2] = lit;
        eLitQ[cyc+2]   = litQ;
        if (lit) begin
            nVec++;
            if (m !== litQ) begin
                nErr++;
                $display("FAIL model_pin cyc=%0d got=%b exp=%b", cyc, m, litQ);
            end
        end
        @(posedge ClkxCI);
        #1;
    endtask

    task automatic sendRand(input bit v);
        send(v, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
             2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
             ZW'($urandom), 1'b0, 4'b0000);
    endtask

    task automatic markZero(input int c, input bit full);
        eDef[c]    = 1'b1;
        eFull[c]   = full;
        eV[c]      = 1'b0;
        eQ[c]      = 4'b0000;
        eLitDef[c] = 1'b0;
    endtask

    // One-cycle reset pulse landing mid-cycle while a valid operand is being presented.
    task automatic pulseReset();
        int c;
        XxD      = 4'($urandom);
        YxD      = 4'($urandom);
        ValidxSI = 1'b1;
        DeltaxD  = pendDelta;
        ZxD      = pendZ;
        c = cyc;
        #1 RstxRI = 1'b1;
        markZero(c, 1'b1);
        markZero(c + 1, 1'b1);
        markZero(c + 2, 1'b0);
        pendDelta = 4'($urandom);
        pendZ     = ZW'($urandom);
        @(posedge ClkxCI);
        #1 RstxRI = 1'b0;
    endtask

    initial begin
        @(posedge ClkxCI);
        #1;
        repeat (4) begin
            XxD = 4'($urandom); YxD = 4'($urandom);
            DeltaxD = 4'($urandom); ZxD = ZW'($urandom);
            ValidxSI = 1'b1;
            markZero(cyc, 1'b1);
            markZero(cyc + 1, 1'b1);
            markZero(cyc + 2, 1'b1);
            @(posedge ClkxCI);
            #1;
        end
        RstxRI = 1'b0;
        XxD = '0; YxD = '0; DeltaxD = '0; ZxD = '0; ValidxSI = 1'b0;

        repeat (3) begin
            send(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, '0, 1'b0, 4'b0000);
            eFull[cyc+1] = 1'b1;
        end

        // X = Y = one, Delta = W unmasked, Z = 0.
        send(1'b1, 2'b11, 2'b11, 2'b01, 2'b00, 2'b00, 2'b00, '0, 1'b1, 4'b1010);
        send(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, '0, 1'b0, 4'b0000);
        // Same value, Delta re-masked as {2'b11, 2'b10}, random masks and Z.
        send(1'b1, 2'b11, 2'b11, 2'b01, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
             2'b10, ZW'($urandom), 1'b1, 4'b1010);
        send(1'b1, 2'b11, 2'b11, 2'b01, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
             2'b10, ZW'($urandom), 1'b1, 4'b1010);
        // X = W, Y = W^2, Delta = W^2: inv = W, products W^2 and one.
        send(1'b1, 2'b01, 2'b10, 2'b10, 2'b01, 2'b11, 2'b01, ZW'($urandom), 1'b1, 4'b1011);
        // Delta = 0 under various masks.
        for (int k = 0; k < 3; k++)
            send(1'b1, 2'($urandom_range(1, 3)), 2'($urandom_range(1, 3)), 2'b00,
                 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'(k + 1),
                 ZW'($urandom), 1'b1, 4'b0000);

        // Back-to-back stream with bubbles at operands 5 and 9.
        for (int k = 0; k < 16; k++)
            sendRand((k == 5 || k == 9) ? 1'b0 : 1'b1);

        pulseReset();
        for (int k = 0; k < 6; k++)
            sendRand(1'b1);

        repeat (3) sendRand(1'b0);
        repeat (2) @(posedge ClkxCI);
        #6;
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/shared_gf4_inv_outmul_dom.md
Name: shared_gf4_inv_outmul_dom

Overview:
- Second half of the masked GF(2^4) inverter in the DOM AES S-box.
- Consumes the shared GF(2^2) value Delta, i.e. the registered output of the upstream X*B + square-scale stage.
- Inverts Delta share-wise, which is linear. Then multiplies the inverse by both GF(2^2) halves (X = high, Y = low) using two DOM-indep multipliers, producing the shared 4-bit inverse.
- Internally delays X/Y one cycle so they align with Delta, and carries a valid pipeline alongside the data.

Parameters:
- SHARES, 2: number of masking shares (>=2).
- PIPELINED, 1: 1 = register stage after the cross-domain terms. Only the value 1 is supported; any other value is a synthesis error.

Ports:
- ClkxCI  in  1  clock; all FFs on the rising edge.
- RstxRI  in  1  asynchronous, active-high reset.
- ValidxSI  in  1  X/Y valid, presented in the same cycle as the upstream multiplier inputs.
- _XxDI  in  2*SHARES  high GF(2^2) half; share i at bits [2i+1:2i].
- _YxDI  in  2*SHARES  low GF(2^2) half; same packing.
- _DeltaxDI  in  2*SHARES  shared Delta from the upstream stage; arrives one cycle after X/Y.
- _ZxDI  in  2*SHARES*(SHARES-1)  fresh randomness.
  - Lower SHARES*(SHARES-1) bits feed the high multiplier.
  - Upper bits feed the low multiplier.
  - Pair index p occupies bits [2p+1:2p] of each half.
- _QxDO  out  4*SHARES  shared inverse; share i = {hi[1:0], lo[1:0]} at bits [4i+3:4i].
- ValidxSO  out  1  _QxDO valid.

Behaviour:
- GF(2^2) uses the normal basis {W^2, W}.
  - Inverse = square = bit swap: inv(a) = {a[0], a[1]}.
  - Applied per share; no randomness needed.
  - Multiplication uses the existing gf2_mul (N=2).
- Stage A (cycle t, capture): XdlyxDP[i] <= X[i], YdlyxDP[i] <= Y[i], VdlyxSP <= ValidxSI.
- Stage B (cycle t+1, combinational, using Delta presented at t+1 and _ZxDI presented at t+1), with D'[j] = inv(Delta[j]) and R = random pair index:
  - Hi domain term (i==j): Xdly[i]*D'[i].
  - Hi cross term (i!=j): Xdly[i]*D'[j] ^ Zhi[R].
  - R = i + j*(j-1)/2 for j>i; R = j + i*(i-1)/2 for j<i. The transposed term reuses the same Z.
  - Lo terms: identical construction with Ydly and Zlo.
  - All SHARES^2 terms per multiplier are registered (FFhi/FFlo); ValidxSO FF <= VdlyxSP.
- Output (cycle t+2): hi share i = XOR over j of FFhi[i][j]; lo likewise.
  - Compression is combinational after the FFs; no recombination before the register.
- Latency:
  - 2 cycles from X/Y/ValidxSI.
  - 1 cycle from Delta/Z.
  - Throughput: one new operand per cycle; no stall or backpressure.
- Valid: data registers load every cycle regardless of valid. ValidxSO only qualifies the output. Bubbles propagate as ValidxSO=0.
- Reset: all FFs (delay regs, term FFs, valid) clear to 0 asynchronously while RstxRI=1.
  - _QxDO=0 and ValidxSO=0 during reset and in the first cycle after release.
  - Reset mid-stream discards in-flight operands.
  - The first valid output appears 2 cycles after the first ValidxSI sampled post-reset.
- Security: no XOR of different share indices before the term register.
  - Each Z pair is used once per multiplier per cycle.
  - Zhi and Zlo must be independent.

Test Plan:
- Reset: hold RstxRI=1 and toggle inputs -> _QxDO=0, ValidxSO=0; release, no valid input -> outputs stay 0.
- SHARES=2, X=Y=one (share0=2'b11, share1=2'b00), Delta shares {2'b01, 2'b00}, Z=0 -> at t+2, share0 XOR share1 = {2'b10, 2'b10}; ValidxSO=1 exactly at t+2.
- Same as previous but Z random and Delta re-masked as {2'b11, 2'b10} -> recombined output still {2'b10, 2'b10}; individual shares vary with Z.
- Delta=0 (any masking), any X/Y -> recombined output 4'b0000.
- Back-to-back stream of 16 operands (all X,Y,Delta in GF(2^2)^3, random masks and Z), with ValidxSI gaps at operands 5 and 9 -> each recombined Q = {X*inv(Delta), Y*inv(Delta)} against the golden model. ValidxSO mirrors ValidxSI delayed 2 cycles.
- Assert RstxRI for one cycle mid-stream -> outputs 0 immediately (asynchronous), in-flight valids dropped, stream resumes correctly on the next operands.
